// File: rtl/de2i_150_spi_master.sv
// SPI master (mode 0, MSB first) behind an Avalon-MM slave, gated by an external chip-select PIO.
// Transfers start on a TXDATA write while cs_in is high; SCLK half-period is DIV+1 clk cycles.
module de2i_150_spi_master #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIV_DEFAULT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        cs_in,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        irq
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] rxdata_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [7:0]            div_cnt_q;
  logic [7:0]            div_lat_q;
  logic [7:0]            div_q, div_d;
  logic                  irq_en_q, irq_en_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  err_q, err_d;
  logic                  sclk_q, mosi_q, cs_n_q, irq_q;

  logic wr_s, rd_s, busy_s, tx_wr_s, start_s, abort_s, div_hit_s, done_s;
  logic err_set_s, err_clr_s, unused_wdata_s;

  assign wr_s      = chipselect & ~write_n;
  assign rd_s      = chipselect & ~read_n;
  assign busy_s    = (state_q != IDLE);
  assign tx_wr_s   = wr_s & (address == 2'd0);
  assign start_s   = tx_wr_s & cs_in & ~busy_s;
  assign abort_s   = busy_s & ~cs_in;
  assign div_hit_s = (div_cnt_q == div_lat_q);
  assign done_s    = (state_q == SHIFT_HI) & ~abort_s & div_hit_s & (bit_cnt_q == CW'(1));
  assign err_set_s = (tx_wr_s & (busy_s | ~cs_in)) | abort_s;
  assign err_clr_s = wr_s & (address == 2'd2) & writedata[2];
  assign unused_wdata_s = ^writedata;

  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign irq      = irq_q;

  // Register-file next state; completion beats a same-cycle RXDATA read, err set beats clear.
  always_comb begin
    rx_valid_d = rx_valid_q;
    err_d      = err_q;
    div_d      = div_q;
    irq_en_d   = irq_en_q;
    if (done_s) begin
      rx_valid_d = 1'b1;
    end else if (rd_s && (address == 2'd1)) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (wr_s && (address == 2'd3)) begin
      div_d    = writedata[7:0];
      irq_en_d = writedata[8];
    end else begin
      div_d    = div_q;
      irq_en_d = irq_en_q;
    end
  end

  // Control/status registers, chip-select follower and interrupt output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q      <= 8'(DIV_DEFAULT);
      irq_en_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      div_q      <= div_d;
      irq_en_q   <= irq_en_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      irq_q      <= rx_valid_d & irq_en_d;
      cs_n_q     <= ~cs_in;
    end
  end

  // Shift FSM: SHIFT_LO ends with SCLK rising (sample MISO), SHIFT_HI ends with SCLK falling.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rxdata_q   <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= 8'd0;
      div_lat_q  <= 8'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          if (start_s) begin
            state_q    <= SHIFT_LO;
            tx_shift_q <= writedata[DATA_WIDTH-1:0];
            mosi_q     <= writedata[DATA_WIDTH-1];
            bit_cnt_q  <= CW'(DATA_WIDTH);
            div_cnt_q  <= 8'd0;
            div_lat_q  <= div_q;
          end else begin
            mosi_q <= 1'b0;
          end
        end
        SHIFT_LO: begin
          if (abort_s) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
          end else if (div_hit_s) begin
            state_q    <= SHIFT_HI;
            sclk_q     <= 1'b1;
            div_cnt_q  <= 8'd0;
            rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], spi_miso};
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (abort_s) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
          end else if (div_hit_s) begin
            sclk_q    <= 1'b0;
            div_cnt_q <= 8'd0;
            if (bit_cnt_q == CW'(1)) begin
              state_q  <= IDLE;
              mosi_q   <= 1'b0;
              rxdata_q <= rx_shift_q;
            end else begin
              state_q    <= SHIFT_LO;
              bit_cnt_q  <= bit_cnt_q - CW'(1);
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
              mosi_q     <= tx_shift_q[DATA_WIDTH-2];
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-wait-state read mux; TXDATA is write-only and reads 0.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = 32'd0;
      2'd1:    readdata = 32'(rxdata_q);
      2'd2:    readdata = {29'd0, err_q, rx_valid_q, busy_s};
      2'd3:    readdata = {23'd0, irq_en_q, div_q};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_de2i_150_spi_master.sv
// Directed self-checking bench for de2i_150_spi_master with MOSI->MISO loopback.
module tb_de2i_150_spi_master;

  logic        clk = 1'b0;
  logic        reset_n, chipselect, write_n, read_n, cs_in;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        spi_cs_n, spi_sclk, spi_mosi, irq;
  logic        loop_en, miso_drv;
  wire         spi_miso_w = loop_en ? spi_mosi : miso_drv;

  int          total = 0;
  int          bad = 0;
  int          sclk_rises = 0;
  logic [31:0] mosi_seq = 32'd0;
  int          base, cyc;
  logic [31:0] d;

  always #5 clk = ~clk;

  de2i_150_spi_master #(.DATA_WIDTH(16), .DIV_DEFAULT(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .cs_in(cs_in), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso_w), .irq(irq)
  );

  // Record every SCLK rising edge and the MOSI bit presented at it.
  always @(posedge spi_sclk) begin
    sclk_rises <= sclk_rises + 1;
    mosi_seq   <= {mosi_seq[30:0], spi_mosi};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    address = a; writedata = wd; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
    #1;
  endtask

  task automatic av_read_se(output logic [31:0] rd);
    @(negedge clk);
    address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
    #1 rd = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1; address = 2'd2;
    #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] rd);
    address = a;
    #1 rd = readdata;
    address = 2'd2;
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    address = 2'd2;
    #1;
    while (readdata[0] === 1'b1 && n < 2000) begin
      n++;
      @(posedge clk);
      #2;
    end
    if (n >= 2000) check("busy_timeout", 32'(readdata[0]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cs_in = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 2'd0; writedata = 32'd0; loop_en = 1'b1; miso_drv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #2;

    peek(2'd1, d); check("rst_rxdata", d, 32'h0);
    peek(2'd2, d); check("rst_status", d, 32'h0);
    peek(2'd3, d); check("rst_control", d, 32'h004);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    av_write(2'd3, 32'h101);
    peek(2'd3, d); check("ctrl_rw", d, 32'h101);
    @(negedge clk) cs_in = 1'b1;
    #1 check("cs_n_lag", 32'(spi_cs_n), 32'd1);
    @(posedge clk);
    #1 check("cs_n_follow", 32'(spi_cs_n), 32'd0);

    // Loopback, DIV=1: 16 bits * 2 * 2 = 64 busy cycles.
    base = sclk_rises;
    av_write(2'd0, 32'hA5C3);
    wait_idle(cyc);
    check("loop_busy_cycles", 32'(cyc), 32'd64);
    check("loop_status", readdata, 32'h2);
    check("loop_irq", 32'(irq), 32'd1);
    check("loop_sclk_rises", 32'(sclk_rises - base), 32'd16);
    check("loop_mosi_seq", {16'd0, mosi_seq[15:0]}, 32'hA5C3);
    check("loop_sclk_idle", 32'(spi_sclk), 32'd0);
    check("loop_mosi_idle", 32'(spi_mosi), 32'd0);
    av_read_se(d); check("loop_rxdata", d, 32'hA5C3);
    peek(2'd2, d); check("rd_clears_valid", d, 32'h0);
    check("irq_cleared", 32'(irq), 32'd0);

    // Write with cs_in low is ignored and sets err.
    @(negedge clk) cs_in = 1'b0;
    base = sclk_rises;
    av_write(2'd0, 32'h1234);
    repeat (20) @(posedge clk);
    #2;
    check("nocs_sclk_rises", 32'(sclk_rises - base), 32'd0);
    peek(2'd2, d); check("nocs_status", d, 32'h4);
    av_write(2'd2, 32'h4);
    peek(2'd2, d); check("err_w1c", d, 32'h0);

    // Second TXDATA write during a transfer is ignored and flags err.
    @(negedge clk) cs_in = 1'b1;
    base = sclk_rises;
    av_write(2'd0, 32'hFFFF);
    repeat (3) @(posedge clk);
    av_write(2'd0, 32'h0001);
    wait_idle(cyc);
    check("wbusy_sclk_rises", 32'(sclk_rises - base), 32'd16);
    check("wbusy_mosi_seq", {16'd0, mosi_seq[15:0]}, 32'hFFFF);
    check("wbusy_status", readdata, 32'h6);
    av_read_se(d); check("wbusy_rxdata", d, 32'hFFFF);
    av_write(2'd2, 32'h4);
    peek(2'd2, d); check("wbusy_clear", d, 32'h0);

    // Abort by dropping cs_in after 3 SCLK rising edges.
    base = sclk_rises;
    av_write(2'd0, 32'h5555);
    cyc = 0;
    while ((sclk_rises - base) < 3 && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("abort_reach3", 32'(sclk_rises - base), 32'd3);
    @(negedge clk) cs_in = 1'b0;
    @(posedge clk);
    #1;
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    #1;
    check("abort_status", readdata, 32'h4);
    check("abort_rises", 32'(sclk_rises - base), 32'd3);
    peek(2'd1, d); check("abort_rxdata_kept", d, 32'hFFFF);
    av_write(2'd2, 32'h4);

    // DIV=0: busy lasts 32 cycles.
    av_write(2'd3, 32'h100);
    @(negedge clk) cs_in = 1'b1;
    base = sclk_rises;
    av_write(2'd0, 32'h3C5A);
    wait_idle(cyc);
    check("div0_busy_cycles", 32'(cyc), 32'd32);
    check("div0_sclk_rises", 32'(sclk_rises - base), 32'd16);
    av_read_se(d); check("div0_rxdata", d, 32'h3C5A);

    // RXDATA read on the completion edge: completion wins.
    av_write(2'd0, 32'hC3A5);
    repeat (31) @(posedge clk);
    @(negedge clk);
    address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
    #1 check("collide_old_word", readdata, 32'h3C5A);
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1; address = 2'd2;
    #1;
    check("collide_status", readdata, 32'h2);
    check("collide_irq", 32'(irq), 32'd1);
    peek(2'd1, d); check("collide_rxdata", d, 32'hC3A5);

    // Reset in the middle of a transfer.
    av_write(2'd0, 32'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("mrst_sclk", 32'(spi_sclk), 32'd0);
    check("mrst_mosi", 32'(spi_mosi), 32'd0);
    check("mrst_cs_n", 32'(spi_cs_n), 32'd1);
    check("mrst_irq", 32'(irq), 32'd0);
    peek(2'd2, d); check("mrst_status", d, 32'h0);
    peek(2'd3, d); check("mrst_control", d, 32'h004);
    peek(2'd1, d); check("mrst_rxdata", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
